// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-to-parallel collector: FSM encoding,
// default word width and a parity helper.
package sipo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } sipo_state_e;

  localparam int SIPO_W = 4;

  // Returns 1 when the vector holds an odd number of ones.
  function automatic logic odd_parity(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/sipo_hold_buf.sv
// One-entry valid/ready holding register. A word offered while the entry is
// full and not being drained is dropped and raises the sticky ovf flag.
module sipo_hold_buf
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_W
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             dout_rdy,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic             ovf
);

  logic take_s;
  logic drop_s;

  // A drain on the same edge frees the entry for the incoming word.
  assign take_s = load & (~dout_vld | dout_rdy);
  assign drop_s = load & dout_vld & ~dout_rdy;

  // Holding register, valid flag and sticky overflow.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      dout     <= {WIDTH{1'b0}};
      dout_vld <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (take_s) begin
        dout     <= din;
        dout_vld <= 1'b1;
      end else if (dout_vld && dout_rdy) begin
        dout_vld <= 1'b0;
      end else begin
        dout_vld <= dout_vld;
      end
      if (drop_s) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end else begin
        ovf <= ovf;
      end
    end
  end

endmodule

// File: rtl/sipo_collector.sv
// Reassembles the upstream serial stream (LSB first) into WIDTH-bit words.
// Define SIPO_PARITY_EN to expect a trailing even-parity bit per word.
module sipo_collector
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_W,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             frame_start,
  input  logic             sin,
  input  logic             sin_vld,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic             ovf,
  input  logic             ovf_clr,
  output logic             perr,
  output logic             busy
);

  sipo_state_e      state_r;
  sipo_state_e      state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] acc_nxt_s;
  logic [WIDTH-1:0] shifted_s;
  logic [WIDTH-1:0] word_s;
  logic             load_s;
`ifdef SIPO_PARITY_EN
  logic             perr_nxt_s;
  logic             perr_r;
`endif

  assign shifted_s = {sin, acc_r[WIDTH-1:1]};

  // Next-state, counter and accumulator; frame_start beats sin_vld.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    acc_nxt_s   = acc_r;
    load_s      = 1'b0;
    word_s      = shifted_s;
`ifdef SIPO_PARITY_EN
    perr_nxt_s  = 1'b0;
`endif
    if (frame_start) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = {CNT_W{1'b0}};
      acc_nxt_s   = {WIDTH{1'b0}};
    end else if (sin_vld) begin
      case (state_r)
        ST_IDLE: begin
          acc_nxt_s   = shifted_s;
          cnt_nxt_s   = CNT_W'(1);
          state_nxt_s = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (cnt_r == CNT_W'(WIDTH - 1)) begin
`ifdef SIPO_PARITY_EN
            // Word is complete but waits in acc for its parity bit.
            acc_nxt_s   = shifted_s;
            cnt_nxt_s   = cnt_r + CNT_W'(1);
            state_nxt_s = ST_PAR;
`else
            load_s      = 1'b1;
            word_s      = shifted_s;
            acc_nxt_s   = {WIDTH{1'b0}};
            cnt_nxt_s   = {CNT_W{1'b0}};
            state_nxt_s = ST_IDLE;
`endif
          end else begin
            acc_nxt_s = shifted_s;
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end
`ifdef SIPO_PARITY_EN
        ST_PAR: begin
          load_s      = 1'b1;
          word_s      = acc_r;
          perr_nxt_s  = odd_parity(32'(acc_r)) ^ sin;
          acc_nxt_s   = {WIDTH{1'b0}};
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = ST_IDLE;
        end
`endif
        default: begin
          acc_nxt_s   = {WIDTH{1'b0}};
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, bit counter and shift accumulator registers.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      acc_r   <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      acc_r   <= acc_nxt_s;
    end
  end

`ifdef SIPO_PARITY_EN
  // Single-cycle parity error pulse, raised the edge the word is handed off.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      perr_r <= 1'b0;
    end else begin
      perr_r <= perr_nxt_s;
    end
  end
  assign perr = perr_r;
`else
  assign perr = 1'b0;
`endif

  assign busy = (cnt_r != {CNT_W{1'b0}});

  sipo_hold_buf #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk      (clk),
    .clr_n    (clr_n),
    .load     (load_s),
    .din      (word_s),
    .dout_rdy (dout_rdy),
    .ovf_clr  (ovf_clr),
    .dout     (dout),
    .dout_vld (dout_vld),
    .ovf      (ovf)
  );

endmodule

// File: doc/sipo_collector.md
Name: sipo_collector

Overview:
- Downstream consumer of the 4-bit load/shift register stage.
- Samples that stage's serial output (its bit 0) on every shift strobe and reassembles the bits, LSB first, into WIDTH-bit words.
- Presents each completed word through a one-entry holding buffer with a valid/ready handshake.
- Flags overflow when a completed word cannot be buffered.

Parameters:
- WIDTH, 4, word length in bits; must be at least 2.
- CNT_W, $clog2(WIDTH+1), width of the bit counter.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- clr_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- frame_start  input  1  realign; driven by the upstream load strobe.
- sin  input  1  serial data; upstream bit 0.
- sin_vld  input  1  bit strobe; driven by the upstream shift strobe.
- dout  output  WIDTH  assembled word; bit 0 is the first bit received.
- dout_vld  output  1  holding buffer full.
- dout_rdy  input  1  consumer accepts dout.
- ovf  output  1  sticky overflow flag.
- ovf_clr  input  1  clears ovf.
- perr  output  1  parity error pulse; see Optional Feature.
- busy  output  1  partial word in progress (bit count is nonzero).

Behaviour:
- Reset: while clr_n is low at a clk edge, all state clears. state=IDLE, bit count=0, shift accumulator=0, dout=0, dout_vld=0, ovf=0, perr=0, busy=0. Reset mid-word discards the partial word and any buffered word.
- FSM states:
  - IDLE: count=0. sin_vld -> SHIFT.
  - SHIFT: count runs 1..WIDTH-1.
  - PAR: only with the optional feature.
- Bit capture: on each edge where sin_vld=1 and frame_start=0, acc <= {sin, acc[WIDTH-1:1]} and count increments. After WIDTH bits, acc[0] holds the first bit.
- Word completion: the edge that accepts bit WIDTH-1 completes the word.
  - Without parity, the completed word {sin, acc[WIDTH-1:1]} moves to the holding buffer on that same edge.
  - dout_vld rises one cycle after the last bit: latency 1 clk from the final sin_vld.
  - count returns to 0 and state returns to IDLE.
- Handshake: a transfer occurs on an edge where dout_vld=1 and dout_rdy=1.
  - dout is stable while dout_vld=1 and dout_rdy=0.
  - dout_vld falls on the edge after acceptance unless a new word loads on that same edge.
- Simultaneous completion and acceptance: the new word loads and dout_vld stays 1; no overflow.
- Overflow: completion while dout_vld=1 and dout_rdy=0 drops the new word, keeps the old one, and sets ovf.
- ovf handling:
  - ovf_clr=1 clears ovf.
  - A new overflow on the same edge as ovf_clr wins, so ovf is set.
- frame_start: count, acc and state clear (-> IDLE); the holding buffer is untouched.
  - frame_start has priority over sin_vld; a coincident bit is ignored. This matches upstream load-over-shift priority.
- Idle: sin_vld=0 means no state change.
- busy: equals (count != 0).

Optional Feature:
- Macro: SIPO_PARITY_EN.
- Defined:
  - Each word is followed by one extra even-parity bit on sin_vld.
  - After bit WIDTH-1 the FSM enters PAR and the word waits in acc.
  - On the parity strobe, the word goes to the holding buffer (same overflow rules). If the XOR of the data bits and the parity bit is 1, perr pulses high for exactly one cycle.
  - Word latency is 1 clk after the parity strobe.
  - frame_start in PAR aborts the word with no perr.
- Undefined: the PAR state is absent, perr is tied to 0, and framing is WIDTH bits.

Decomposition:
- Shared package sipo_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_PAR=2'd2.
  - Default word width constant SIPO_W=4, matching the upstream stage.
- One natural sub-module: sipo_hold_buf, the one-entry valid/ready holding register with overflow detection.
- The FSM, counter and accumulator stay in the top module.

Test Plan:
- Reset then idle: clr_n=0 for 2 clk with random sin -> all outputs 0. Release with sin_vld=0 -> outputs remain 0.
- Basic word, WIDTH=4: sin_vld held 4 cycles with sin=0,1,0,1 -> dout=4'hA, dout_vld=1 one clk after the 4th strobe. dout_rdy=1 -> dout_vld=0 the next clk.
- Overflow: complete 4'h3, hold dout_rdy=0, then complete 4'hC -> dout stays 4'h3 and ovf=1. ovf_clr pulse -> ovf=0.
- Back-to-back with acceptance: complete 4'h5, then assert dout_rdy=1 on the edge where 4'h9 completes -> dout=4'h9, dout_vld stays 1, ovf=0.
- Realign and reset mid-word:
  - 2 bits, then frame_start with sin_vld=1, then bits 1,1,1,1 -> dout=4'hF; the coincident bit is ignored.
  - 2 bits, then clr_n=0 -> busy=0 and no word is produced.
- SIPO_PARITY_EN build:
  - Bits 1,1,0,0 with parity 0 -> dout=4'h3, perr=0.
  - Bits 1,0,0,0 with parity 0 -> dout=4'h1, perr pulses exactly one cycle.
